// File: rtl/multicycle_control_fsm_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm_if
//   Bundles the signals between the multicycle main control FSM and the
//   16-bit MIPS datapath and memory.
//
//   Handshake: mem_read or mem_write is held high for as long as an access
//   is outstanding. mem_ready high in a cycle means the memory finishes that
//   access in this same cycle. The access is retired at the next rising clk.
//   mem_ready is ignored in any cycle where no access is outstanding.
//
//   master modport : the control FSM (takes opcode/funct/mem_ready, drives
//                    enables, selects, alu_op, debug state and illegal)
//   slave modport  : the datapath/memory side
// ---------------------------------------------------------------------------
interface multicycle_control_fsm_if;
   logic [3:0] opcode;         // IR[15:12]
   logic [3:0] funct;          // IR[3:0]
   logic       mem_ready;      // memory completes the access this cycle
   logic       pc_write;
   logic       pc_write_cond;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] reg_dst;        // 00 rt, 01 rd, 10 r7
   logic [1:0] mem_to_reg;     // 00 ALUOut, 01 MDR, 10 PC
   logic [1:0] alu_src_b;      // 00 B, 01 const 2, 10 imm, 11 imm<<1
   logic [1:0] pc_source;      // 00 ALU, 01 ALUOut, 10 jump, 11 reg A
   logic [1:0] alu_op;         // 11 add, 01 sub, 10 slt, 00 funct
   logic [3:0] state;          // debug view of the FSM state
   logic       illegal;        // sticky illegal-opcode flag

   modport master (
      input  opcode, funct, mem_ready,
      output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
             reg_write, alu_src_a, reg_dst, mem_to_reg, alu_src_b,
             pc_source, alu_op, state, illegal
   );

   modport slave (
      output opcode, funct, mem_ready,
      input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
             reg_write, alu_src_a, reg_dst, mem_to_reg, alu_src_b,
             pc_source, alu_op, state, illegal
   );
endinterface

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//   Main control state machine of the multicycle 16-bit MIPS processor.
//   Steps each instruction through fetch, decode, execute, memory and
//   writeback, and drives the datapath enables/selects plus the 2-bit alu_op
//   that feeds the ALU-control/JR decoder.
//
//   Ports:
//     clk   : single clock, rising edge
//     reset : asynchronous, active-high; all outputs read 0 while high
//     bus   : multicycle_control_fsm_if.master (opcode/funct/mem_ready in,
//             enables, selects, alu_op, debug state and illegal out)
// ---------------------------------------------------------------------------
module multicycle_control_fsm (
   input  logic                    clk,
   input  logic                    reset,
   multicycle_control_fsm_if.master bus
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_ALU_WB    = 4'd7,
      S_IMM_EXEC  = 4'd8,
      S_IMM_WB    = 4'd9,
      S_BRANCH    = 4'd10,
      S_JUMP      = 4'd11,
      S_JAL       = 4'd12,
      S_JR        = 4'd13,
      S_ILLEGAL   = 4'd14
   } state_t;

   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_LW    = 4'b0001;
   localparam logic [3:0] OP_SW    = 4'b0010;
   localparam logic [3:0] OP_BEQ   = 4'b0011;
   localparam logic [3:0] OP_ADDI  = 4'b0100;
   localparam logic [3:0] OP_SLTI  = 4'b0101;
   localparam logic [3:0] OP_J     = 4'b0110;
   localparam logic [3:0] OP_JAL   = 4'b0111;
   localparam logic [3:0] FUNCT_JR = 4'b1000;

   localparam logic [1:0] ALU_FUNCT = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_SLT   = 2'b10;
   localparam logic [1:0] ALU_ADD   = 2'b11;

   state_t state_q;
   state_t state_d;
   logic   illegal_q;

   logic       pc_write;
   logic       pc_write_cond;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] reg_dst;
   logic [1:0] mem_to_reg;
   logic [1:0] alu_src_b;
   logic [1:0] pc_source;
   logic [1:0] alu_op;

   // State register and sticky illegal flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_q | (state_d == S_ILLEGAL);
      end
   end

   // Next-state logic. opcode/funct are only looked at in DECODE, MEM_ADDR
   // and IMM_EXEC, where the IR cannot change.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_FETCH:     state_d = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            unique case (bus.opcode)
               OP_LW, OP_SW:     state_d = S_MEM_ADDR;
               OP_RTYPE:         state_d = (bus.funct == FUNCT_JR) ? S_JR : S_EXECUTE;
               OP_ADDI, OP_SLTI: state_d = S_IMM_EXEC;
               OP_BEQ:           state_d = S_BRANCH;
               OP_J:             state_d = S_JUMP;
               OP_JAL:           state_d = S_JAL;
               default:          state_d = S_ILLEGAL;
            endcase
         end
         // Only lw and sw reach MEM_ADDR.
         S_MEM_ADDR:  state_d = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  state_d = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
         S_MEM_WB:    state_d = S_FETCH;
         S_MEM_WRITE: state_d = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
         S_EXECUTE:   state_d = S_ALU_WB;
         S_ALU_WB:    state_d = S_FETCH;
         S_IMM_EXEC:  state_d = S_IMM_WB;
         S_IMM_WB:    state_d = S_FETCH;
         S_BRANCH:    state_d = S_FETCH;
         S_JUMP:      state_d = S_FETCH;
         S_JAL:       state_d = S_FETCH;
         S_JR:        state_d = S_FETCH;
         S_ILLEGAL:   state_d = S_ILLEGAL;
         default:     state_d = S_FETCH;
      endcase
   end

   // Output decode from the current state.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      reg_dst       = 2'b00;
      mem_to_reg    = 2'b00;
      alu_src_b     = 2'b00;
      pc_source     = 2'b00;
      alu_op        = ALU_FUNCT;
      unique case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            alu_op    = ALU_ADD;
            pc_source = 2'b00;
            // IR load and PC+2 happen only in the cycle the fetch completes,
            // so each fires exactly once however long memory stalls.
            ir_write  = bus.mem_ready;
            pc_write  = bus.mem_ready;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;   // branch target into ALUOut
            alu_op    = ALU_ADD;
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = ALU_ADD;
         end
         S_MEM_READ: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            reg_dst    = 2'b00;
            mem_to_reg = 2'b01;
         end
         S_MEM_WRITE: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         S_EXECUTE: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b00;
            alu_op    = ALU_FUNCT;
         end
         S_ALU_WB: begin
            reg_write  = 1'b1;
            reg_dst    = 2'b01;
            mem_to_reg = 2'b00;
         end
         S_IMM_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = (bus.opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
         end
         S_IMM_WB: begin
            reg_write  = 1'b1;
            reg_dst    = 2'b00;
            mem_to_reg = 2'b00;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_src_b     = 2'b00;
            alu_op        = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         S_JAL: begin
            pc_write   = 1'b1;
            pc_source  = 2'b10;
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
         end
         S_JR: begin
            pc_write  = 1'b1;
            pc_source = 2'b11;
            // Downstream JR decoder recognises {alu_op, funct} = {00, 1000}.
            alu_op    = ALU_FUNCT;
         end
         default: begin
            // ILLEGAL and the unused encoding drive nothing.
         end
      endcase
   end

   // While reset is high every output is forced low, including the FETCH
   // mem_read that the reset state would otherwise present.
   assign bus.pc_write      = ~reset & pc_write;
   assign bus.pc_write_cond = ~reset & pc_write_cond;
   assign bus.iord          = ~reset & iord;
   assign bus.mem_read      = ~reset & mem_read;
   assign bus.mem_write     = ~reset & mem_write;
   assign bus.ir_write      = ~reset & ir_write;
   assign bus.reg_write     = ~reset & reg_write;
   assign bus.alu_src_a     = ~reset & alu_src_a;
   assign bus.reg_dst       = reset ? 2'b00 : reg_dst;
   assign bus.mem_to_reg    = reset ? 2'b00 : mem_to_reg;
   assign bus.alu_src_b     = reset ? 2'b00 : alu_src_b;
   assign bus.pc_source     = reset ? 2'b00 : pc_source;
   assign bus.alu_op        = reset ? 2'b00 : alu_op;
   assign bus.state         = reset ? 4'd0  : state_q;
   assign bus.illegal       = ~reset & illegal_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
//   Bench for multicycle_control_fsm. Each cycle the driver applies
//   reset/opcode/funct/mem_ready and queues the full expected output word;
//   the monitor compares on the falling edge. The expected words come from
//   the per-state output table of the control unit.
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;

   localparam int W = 23;

   typedef struct {
      logic         rst;
      logic [3:0]   opcode;
      logic [3:0]   funct;
      logic         mem_ready;
      logic [W-1:0] exp;
      string        tag;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   multicycle_control_fsm_if bus();

   multicycle_control_fsm dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   string        tag_q[$];
   int           n_cmp  = 0;
   int           n_fail = 0;
   logic [W-1:0] mon_exp;
   logic [W-1:0] mon_act;
   string        mon_tag;

   // Word layout: state, illegal, {pc_write, pc_write_cond, iord, mem_read,
   // mem_write, ir_write, reg_write, alu_src_a}, reg_dst, mem_to_reg,
   // alu_src_b, pc_source, alu_op.
   function automatic logic [W-1:0] ow(input logic [3:0] st, input logic il,
                                       input logic [7:0] en,
                                       input logic [1:0] rd, input logic [1:0] m2r,
                                       input logic [1:0] asb, input logic [1:0] pcs,
                                       input logic [1:0] aop);
      return {st, il, en, rd, m2r, asb, pcs, aop};
   endfunction

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_exp = exp_q.pop_front();
         mon_tag = tag_q.pop_front();
         mon_act = {bus.state, bus.illegal, bus.pc_write, bus.pc_write_cond,
                    bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
                    bus.reg_write, bus.alu_src_a, bus.reg_dst, bus.mem_to_reg,
                    bus.alu_src_b, bus.pc_source, bus.alu_op};
         n_cmp++;
         if (mon_act !== mon_exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%06h required=%06h (state act=%0d req=%0d)",
                     mon_tag, $time, mon_act, mon_exp, mon_act[22:19], mon_exp[22:19]);
         end
      end
   end

   // ---------------- driver ----------------
   task automatic drive_cycle(input logic rst, input logic [3:0] op,
                              input logic [3:0] fn, input logic mr,
                              input logic [W-1:0] exp, input string tag);
      @(posedge clk);
      #1;
      reset         = rst;
      bus.opcode    = op;
      bus.funct     = fn;
      bus.mem_ready = mr;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
   endtask

   // ---------------- expected words ----------------
   logic [W-1:0] e_zero, e_fetch, e_fetch_w, e_decode, e_mem_addr, e_mem_read;
   logic [W-1:0] e_mem_wb, e_mem_write, e_execute, e_alu_wb, e_addi_ex;
   logic [W-1:0] e_slti_ex, e_imm_wb, e_branch, e_jump, e_jal, e_jr, e_illegal;

   vec_t vecs[$];

   task automatic add(input logic [3:0] op, input logic [3:0] fn, input logic mr,
                      input logic [W-1:0] exp, input string tag);
      vec_t v;
      v.rst = 1'b0; v.opcode = op; v.funct = fn; v.mem_ready = mr;
      v.exp = exp; v.tag = tag;
      vecs.push_back(v);
   endtask

   initial begin
      reset         = 1'b1;
      bus.opcode    = 4'd0;
      bus.funct     = 4'd0;
      bus.mem_ready = 1'b0;

      //                 st     il    pw,pwc,iord,mr,mw,irw,rw,asa  rd     m2r    asb    pcs    aop
      e_zero      = '0;
      e_fetch     = ow(4'd0,  1'b0, 8'b1001_0100, 2'd0, 2'd0, 2'd1, 2'd0, 2'd3);
      e_fetch_w   = ow(4'd0,  1'b0, 8'b0001_0000, 2'd0, 2'd0, 2'd1, 2'd0, 2'd3);
      e_decode    = ow(4'd1,  1'b0, 8'b0000_0000, 2'd0, 2'd0, 2'd3, 2'd0, 2'd3);
      e_mem_addr  = ow(4'd2,  1'b0, 8'b0000_0001, 2'd0, 2'd0, 2'd2, 2'd0, 2'd3);
      e_mem_read  = ow(4'd3,  1'b0, 8'b0011_0000, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
      e_mem_wb    = ow(4'd4,  1'b0, 8'b0000_0010, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0);
      e_mem_write = ow(4'd5,  1'b0, 8'b0010_1000, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
      e_execute   = ow(4'd6,  1'b0, 8'b0000_0001, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
      e_alu_wb    = ow(4'd7,  1'b0, 8'b0000_0010, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0);
      e_addi_ex   = ow(4'd8,  1'b0, 8'b0000_0001, 2'd0, 2'd0, 2'd2, 2'd0, 2'd3);
      e_slti_ex   = ow(4'd8,  1'b0, 8'b0000_0001, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2);
      e_imm_wb    = ow(4'd9,  1'b0, 8'b0000_0010, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
      e_branch    = ow(4'd10, 1'b0, 8'b0100_0001, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1);
      e_jump      = ow(4'd11, 1'b0, 8'b1000_0000, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0);
      e_jal       = ow(4'd12, 1'b0, 8'b1000_0010, 2'd2, 2'd2, 2'd0, 2'd2, 2'd0);
      e_jr        = ow(4'd13, 1'b0, 8'b1000_0000, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0);
      e_illegal   = ow(4'd14, 1'b1, 8'b0000_0000, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);

      // ---- vector table: one entry per cycle ----
      // R-type add; mem_ready low in DECODE/EXECUTE must be ignored
      add(4'd0, 4'd0, 1'b1, e_fetch,     "radd_fetch");
      add(4'd0, 4'd0, 1'b0, e_decode,    "radd_decode");
      add(4'd0, 4'd0, 1'b0, e_execute,   "radd_execute");
      add(4'd0, 4'd0, 1'b1, e_alu_wb,    "radd_alu_wb");
      // R-type other funct
      add(4'd0, 4'd2, 1'b1, e_fetch,     "rsub_fetch");
      add(4'd0, 4'd2, 1'b1, e_decode,    "rsub_decode");
      add(4'd0, 4'd2, 1'b1, e_execute,   "rsub_execute");
      add(4'd0, 4'd2, 1'b1, e_alu_wb,    "rsub_alu_wb");
      // lw with two wait cycles in MEM_READ: 0,1,2,3,3,3,4
      add(4'd1, 4'd0, 1'b1, e_fetch,     "lw_fetch");
      add(4'd1, 4'd0, 1'b1, e_decode,    "lw_decode");
      add(4'd1, 4'd0, 1'b0, e_mem_addr,  "lw_mem_addr");
      add(4'd1, 4'd0, 1'b0, e_mem_read,  "lw_mem_read0");
      add(4'd1, 4'd0, 1'b0, e_mem_read,  "lw_mem_read1");
      add(4'd1, 4'd0, 1'b1, e_mem_read,  "lw_mem_read2");
      add(4'd1, 4'd0, 1'b0, e_mem_wb,    "lw_mem_wb");
      // sw with one fetch stall and one write stall
      add(4'd2, 4'd0, 1'b0, e_fetch_w,   "sw_fetch_wait");
      add(4'd2, 4'd0, 1'b1, e_fetch,     "sw_fetch");
      add(4'd2, 4'd0, 1'b1, e_decode,    "sw_decode");
      add(4'd2, 4'd0, 1'b1, e_mem_addr,  "sw_mem_addr");
      add(4'd2, 4'd0, 1'b0, e_mem_write, "sw_mem_write0");
      add(4'd2, 4'd0, 1'b1, e_mem_write, "sw_mem_write1");
      // beq then jr
      add(4'd3, 4'd0, 1'b1, e_fetch,     "beq_fetch");
      add(4'd3, 4'd0, 1'b1, e_decode,    "beq_decode");
      add(4'd3, 4'd0, 1'b1, e_branch,    "beq_branch");
      add(4'd0, 4'd8, 1'b1, e_fetch,     "jr_fetch");
      add(4'd0, 4'd8, 1'b1, e_decode,    "jr_decode");
      add(4'd0, 4'd8, 1'b1, e_jr,        "jr_jr");
      // addi, slti
      add(4'd4, 4'd0, 1'b1, e_fetch,     "addi_fetch");
      add(4'd4, 4'd0, 1'b1, e_decode,    "addi_decode");
      add(4'd4, 4'd0, 1'b1, e_addi_ex,   "addi_exec");
      add(4'd4, 4'd0, 1'b1, e_imm_wb,    "addi_wb");
      add(4'd5, 4'd0, 1'b1, e_fetch,     "slti_fetch");
      add(4'd5, 4'd0, 1'b1, e_decode,    "slti_decode");
      add(4'd5, 4'd0, 1'b1, e_slti_ex,   "slti_exec");
      add(4'd5, 4'd0, 1'b1, e_imm_wb,    "slti_wb");
      // j, jal
      add(4'd6, 4'd0, 1'b1, e_fetch,     "j_fetch");
      add(4'd6, 4'd0, 1'b1, e_decode,    "j_decode");
      add(4'd6, 4'd0, 1'b1, e_jump,      "j_jump");
      add(4'd7, 4'd0, 1'b1, e_fetch,     "jal_fetch");
      add(4'd7, 4'd0, 1'b1, e_decode,    "jal_decode");
      add(4'd7, 4'd0, 1'b0, e_jal,       "jal_jal");

      // ---- initial reset: all outputs 0 ----
      drive_cycle(1'b1, 4'd0, 4'd0, 1'b1, e_zero, "por_hold0");
      drive_cycle(1'b1, 4'd0, 4'd0, 1'b1, e_zero, "por_hold1");

      // ---- table sweep ----
      for (int i = 0; i < vecs.size(); i++)
         drive_cycle(vecs[i].rst, vecs[i].opcode, vecs[i].funct,
                     vecs[i].mem_ready, vecs[i].exp, vecs[i].tag);

      // ---- reset pulse mid-MEM_READ with mem_ready low ----
      drive_cycle(1'b0, 4'd1, 4'd0, 1'b1, e_fetch,    "rst_lw_fetch");
      drive_cycle(1'b0, 4'd1, 4'd0, 1'b1, e_decode,   "rst_lw_decode");
      drive_cycle(1'b0, 4'd1, 4'd0, 1'b1, e_mem_addr, "rst_lw_mem_addr");
      drive_cycle(1'b0, 4'd1, 4'd0, 1'b0, e_mem_read, "rst_lw_mem_read");
      drive_cycle(1'b1, 4'd1, 4'd0, 1'b1, e_zero,     "rst_mid_hold0");
      drive_cycle(1'b1, 4'd1, 4'd0, 1'b0, e_zero,     "rst_mid_hold1");
      drive_cycle(1'b0, 4'd6, 4'd0, 1'b0, e_fetch_w,  "rst_release_fetch");
      drive_cycle(1'b0, 4'd6, 4'd0, 1'b1, e_fetch,    "rst_after_fetch");
      drive_cycle(1'b0, 4'd6, 4'd0, 1'b1, e_decode,   "rst_after_decode");
      drive_cycle(1'b0, 4'd6, 4'd0, 1'b1, e_jump,     "rst_after_jump");

      // ---- illegal opcode 1010: terminal until reset ----
      drive_cycle(1'b0, 4'b1010, 4'd0, 1'b1, e_fetch,  "ill_fetch");
      drive_cycle(1'b0, 4'b1010, 4'd0, 1'b1, e_decode, "ill_decode");
      for (int i = 0; i < 20; i++)
         drive_cycle(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), e_illegal, "ill_hold");
      drive_cycle(1'b1, 4'd0, 4'd0, 1'b1, e_zero,    "ill_reset");
      drive_cycle(1'b0, 4'd0, 4'd0, 1'b0, e_fetch_w, "ill_cleared_fetch");
      drive_cycle(1'b0, 4'd0, 4'd0, 1'b1, e_fetch,   "ill_after_fetch");
      drive_cycle(1'b0, 4'd0, 4'd0, 1'b1, e_decode,  "ill_after_decode");
      drive_cycle(1'b0, 4'd0, 4'd0, 1'b1, e_execute, "ill_after_execute");
      drive_cycle(1'b0, 4'd0, 4'd0, 1'b1, e_alu_wb,  "ill_after_alu_wb");

      // ---- drain and report ----
      @(negedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
